// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: independent toggles (BANK) or a chained up/down counter (COUNT).
// Define TFF_BANK_EDGE_EN to make t rising-edge sensitive instead of level-sensitive.
module tff_bank #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic [WIDTH-1:0] t,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] q_reg, q_next;
   logic             wrap_reg, wrap_next;
   logic [WIDTH-1:0] tt;
   logic [WIDTH-1:0] ones_below, zeros_below, cnt_tog;
   logic             at_limit;

`ifdef TFF_BANK_EDGE_EN
   logic [WIDTH-1:0] t_d_reg;

   // History tracks t on every edge so a held t only acts once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) t_d_reg <= '0;
      else      t_d_reg <= t;
   end

   assign tt = t & ~t_d_reg;
`else
   assign tt = t;
`endif

   // Counter T inputs: bit gi toggles when every lower bit sits at the carry/borrow value.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         if (gi == 0) begin : g_lsb
            assign ones_below[gi]  = 1'b1;
            assign zeros_below[gi] = 1'b1;
         end else begin : g_upper
            assign ones_below[gi]  = ones_below[gi-1] & q_reg[gi-1];
            assign zeros_below[gi] = zeros_below[gi-1] & ~q_reg[gi-1];
         end
         assign cnt_tog[gi] = dir ? ones_below[gi] : zeros_below[gi];
      end
   endgenerate

   assign at_limit = dir ? (&q_reg) : ~(|q_reg);

   always_comb begin
      q_next    = q_reg;
      wrap_next = 1'b0;
      if (clr) begin
         q_next = RST_VAL;
      end else if (load) begin
         q_next = load_val;
      end else if (en) begin
         if (!mode) begin
            q_next = q_reg ^ tt;
         end else if (tt[0]) begin
            if (at_limit && SATURATE) begin
               q_next = q_reg;
            end else begin
               q_next    = q_reg ^ cnt_tog;
               wrap_next = at_limit;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg    <= RST_VAL;
         wrap_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         wrap_reg <= wrap_next;
      end
   end

   assign q    = q_reg;
   assign wrap = wrap_reg;
   assign tc   = mode & at_limit;

endmodule

// File: tb/tb_tff_bank.sv
// Directed-vector bench for tff_bank (default level-sensitive build): a wrapping instance
// with RST_VAL=5 and a saturating twin sharing the same stimulus.
module tb_tff_bank;

   logic       clk = 1'b0;
   logic       rst, en, mode, dir, clr, load;
   logic [3:0] t, load_val;
   logic [3:0] q_a, q_b;
   logic       tc_a, tc_b, wrap_a, wrap_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tff_bank #(.WIDTH(4), .RST_VAL(4'h5), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .t(t),
      .clr(clr), .load(load), .load_val(load_val),
      .q(q_a), .tc(tc_a), .wrap(wrap_a)
   );

   tff_bank #(.WIDTH(4), .RST_VAL(4'h5), .SATURATE(1'b1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .t(t),
      .clr(clr), .load(load), .load_val(load_val),
      .q(q_b), .tc(tc_b), .wrap(wrap_b)
   );

   typedef struct packed {
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic       en;
      logic       mode;
      logic       dir;
      logic [3:0] t;
      logic [3:0] eq;
      logic       etc;
      logic       ewrap;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic [3:0] lv, input logic e,
                        input logic m, input logic d, input logic [3:0] tv);
      clr = c; load = l; load_val = lv; en = e; mode = m; dir = d; t = tv;
   endtask

   // Apply current inputs across one rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             clr  load lv     en   mode dir  t        q      tc   wrap
      vecs[0]  = '{1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,4'b0000,4'h0,1'b0,1'b0}; // load 0
      vecs[1]  = '{1'b0,1'b0,4'h0,1'b1,1'b0,1'b0,4'b1010,4'hA,1'b0,1'b0}; // bank toggle
      vecs[2]  = '{1'b0,1'b0,4'h0,1'b1,1'b0,1'b0,4'b1010,4'h0,1'b0,1'b0}; // held t toggles back
      vecs[3]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,4'b1111,4'h0,1'b0,1'b0}; // en=0 freezes
      vecs[4]  = '{1'b0,1'b0,4'h0,1'b1,1'b0,1'b0,4'b0011,4'h3,1'b0,1'b0}; // bank to 3
      vecs[5]  = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,4'b0001,4'h4,1'b0,1'b0}; // switch to count up
      vecs[6]  = '{1'b0,1'b1,4'hE,1'b1,1'b1,1'b1,4'b0001,4'hE,1'b0,1'b0}; // load E
      vecs[7]  = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,4'b0001,4'hF,1'b1,1'b0}; // up to limit
      vecs[8]  = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,4'b0001,4'h0,1'b0,1'b1}; // wrap up
      vecs[9]  = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,4'b0001,4'h1,1'b0,1'b0}; // pulse is 1 cycle
      vecs[10] = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,4'b1110,4'h1,1'b0,1'b0}; // t[3:1] ignored
      vecs[11] = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,4'b0001,4'h0,1'b1,1'b0}; // down to 0
      vecs[12] = '{1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,4'b0001,4'hF,1'b0,1'b1}; // wrap down
      vecs[13] = '{1'b1,1'b1,4'h9,1'b1,1'b1,1'b0,4'b1111,4'h5,1'b0,1'b0}; // clr beats load
      vecs[14] = '{1'b0,1'b1,4'h9,1'b0,1'b1,1'b0,4'b0000,4'h9,1'b0,1'b0}; // load only
      vecs[15] = '{1'b0,1'b0,4'h0,1'b1,1'b0,1'b0,4'b0000,4'h9,1'b0,1'b0}; // bank, no toggles
      vecs[16] = '{1'b0,1'b1,4'h0,1'b1,1'b1,1'b0,4'b0001,4'h0,1'b1,1'b0}; // load at limit: no wrap

      rst = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      #22;
      check("reset_q", q_a, 4'h5);
      check("reset_wrap", {3'b0, wrap_a}, 4'h0);
      check("reset_tc", {3'b0, tc_a}, 4'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en,
               vecs[i].mode, vecs[i].dir, vecs[i].t);
         tick();
         $display("vec %0d: q=%h tc=%b wrap=%b (want %h %b %b)", i, q_a, tc_a, wrap_a,
                  vecs[i].eq, vecs[i].etc, vecs[i].ewrap);
         check($sformatf("vec%0d_q", i), q_a, vecs[i].eq);
         check($sformatf("vec%0d_tc", i), {3'b0, tc_a}, {3'b0, vecs[i].etc});
         check($sformatf("vec%0d_wrap", i), {3'b0, wrap_a}, {3'b0, vecs[i].ewrap});
      end

      // Saturate vs wrap counting down from 1 for three steps.
      drive(1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 4'b0001);
      tick();
      check("sat_load_q", q_b, 4'h1);
      drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0001);
      for (int s = 0; s < 3; s++) begin
         tick();
         $display("sat step %0d: q_b=%h tc_b=%b wrap_b=%b q_a=%h wrap_a=%b",
                  s, q_b, tc_b, wrap_b, q_a, wrap_a);
         check($sformatf("sat%0d_q", s), q_b, 4'h0);
         check($sformatf("sat%0d_tc", s), {3'b0, tc_b}, 4'h1);
         check($sformatf("sat%0d_wrap", s), {3'b0, wrap_b}, 4'h0);
      end
      check("wrapinst_q", q_a, 4'hE);
      check("wrapinst_wrap", {3'b0, wrap_a}, 4'h0);

      // Async reset right after a wrap: q returns immediately and the pulse is killed.
      drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0001);
      tick();
      drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0001);
      tick();
      check("prewrap_q", q_a, 4'hF);
      check("prewrap_wrap", {3'b0, wrap_a}, 4'h1);
      #2;
      rst = 1'b0;
      #1;
      $display("mid reset: q_a=%h wrap_a=%b q_b=%h", q_a, wrap_a, q_b);
      check("midrst_q", q_a, 4'h5);
      check("midrst_wrap", {3'b0, wrap_a}, 4'h0);
      check("midrst_qb", q_b, 4'h5);
      tick();
      check("rsthold_q", q_a, 4'h5);
      @(negedge clk);
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
